// File: rtl/axi_register_bank.sv
// AXI4-Lite register bank: ID, W1C EVENT, IRQ_EN, PULSE, NUM_CTRL control words and NUM_STAT status words.
// Optional macro AXI_REG_BANK_IRQ_EN enables the IRQ_EN register and the level irq output.
module axi_register_bank #(
    parameter int          C_S_AXI_DATA_WIDTH = 32,
    parameter int          C_S_AXI_ADDR_WIDTH = 8,
    parameter int          NUM_CTRL           = 4,
    parameter int          NUM_STAT           = 4,
    parameter logic [31:0] CTRL_RESET         = 32'h0,
    parameter logic [31:0] ID_VALUE           = 32'h5A4D_0100
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    output logic [NUM_CTRL*32-1:0]            ctrl_out,
    output logic [31:0]                       ctrl_pulse,
    input  logic [NUM_STAT*32-1:0]            stat_in,
    input  logic [31:0]                       event_in,
    output logic                              irq
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int IW        = C_S_AXI_ADDR_WIDTH - 2;
    localparam int STAT_BASE = 4 + NUM_CTRL;
    localparam int MAP_END   = STAT_BASE + NUM_STAT;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    logic          aw_held_q;
    logic [IW-1:0] aw_idx_q;
    logic          w_held_q;
    logic [DW-1:0] w_data_q;
    logic [DW/8-1:0] w_strb_q;
    logic          bvalid_q;
    logic [1:0]    bresp_q;
    logic          rvalid_q;
    logic [1:0]    rresp_q;
    logic [DW-1:0] rdata_q;
    logic [31:0]   event_q;
    logic [31:0]   pulse_q;

    logic            aw_hs, w_hs, ar_hs, commit;
    logic [IW-1:0]   wr_idx_bits;
    int              wr_idx, rd_idx;
    logic [DW-1:0]   wr_data;
    logic [DW/8-1:0] wr_strb;
    logic [DW-1:0]   wr_mask;
    logic [1:0]      bresp_d;
    logic [DW-1:0]   rdata_d;
    logic [1:0]      rresp_d;
    logic [31:0]     event_d;
    logic [31:0]     pulse_d;

    logic unused_ok;
    assign unused_ok = ^{s00_axi_awprot, s00_axi_arprot, s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    assign s00_axi_awready = !aw_held_q && !bvalid_q;
    assign s00_axi_wready  = !w_held_q && !bvalid_q;
    assign s00_axi_arready = !rvalid_q;
    assign s00_axi_bvalid  = bvalid_q;
    assign s00_axi_bresp   = bresp_q;
    assign s00_axi_rvalid  = rvalid_q;
    assign s00_axi_rresp   = rresp_q;
    assign s00_axi_rdata   = rdata_q;
    assign ctrl_pulse      = pulse_q;

    assign aw_hs = s00_axi_awvalid && s00_axi_awready;
    assign w_hs  = s00_axi_wvalid && s00_axi_wready;
    assign ar_hs = s00_axi_arvalid && s00_axi_arready;

    // A buffered half and a live handshake of the other half may combine on the same edge.
    assign commit      = (aw_held_q || aw_hs) && (w_held_q || w_hs);
    assign wr_idx_bits = aw_held_q ? aw_idx_q : s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data     = w_held_q ? w_data_q : s00_axi_wdata;
    assign wr_strb     = w_held_q ? w_strb_q : s00_axi_wstrb;
    assign wr_idx      = int'(wr_idx_bits);
    assign rd_idx      = int'(s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2]);

    for (genvar gi = 0; gi < DW / 8; gi++) begin : g_mask
        assign wr_mask[gi*8 +: 8] = {8{wr_strb[gi]}};
    end

    // Words 1..3 and CTRL accept writes; ID, STAT and holes answer SLVERR.
    assign bresp_d = (wr_idx >= 1 && wr_idx < STAT_BASE) ? RESP_OKAY : RESP_SLVERR;

    for (genvar gi = 0; gi < NUM_CTRL; gi++) begin : g_ctrl
        logic [DW-1:0] word_q;
        logic [DW-1:0] word_d;
        assign word_d = (commit && wr_idx == 4 + gi) ? ((word_q & ~wr_mask) | (wr_data & wr_mask))
                                                     : word_q;
        always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
            if (!s00_axi_aresetn) begin
                word_q <= CTRL_RESET;
            end else begin
                word_q <= word_d;
            end
        end
        assign ctrl_out[gi*32 +: 32] = word_q;
    end

`ifdef AXI_REG_BANK_IRQ_EN
    logic [31:0] irq_en_q;
    logic [31:0] irq_en_d;
    logic        irq_q;
    assign irq_en_d = (commit && wr_idx == 2) ? ((irq_en_q & ~wr_mask) | (wr_data & wr_mask))
                                              : irq_en_q;
    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            irq_en_q <= '0;
            irq_q    <= 1'b0;
        end else begin
            irq_en_q <= irq_en_d;
            irq_q    <= |(event_q & irq_en_q);
        end
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

    // Event sets are applied after the W1C clear so a coincident set wins.
    assign event_d = (event_q & ~((commit && wr_idx == 1) ? (wr_data & wr_mask) : '0)) | event_in;
    assign pulse_d = (commit && wr_idx == 3) ? (wr_data & wr_mask) : '0;

    always_comb begin
        rdata_d = '0;
        rresp_d = RESP_OKAY;
        if (rd_idx == 0) begin
            rdata_d = ID_VALUE;
        end else if (rd_idx == 1) begin
            rdata_d = event_q;
        end else if (rd_idx == 2) begin
`ifdef AXI_REG_BANK_IRQ_EN
            rdata_d = irq_en_q;
`else
            rdata_d = '0;
`endif
        end else if (rd_idx == 3) begin
            rdata_d = '0;
        end else if (rd_idx < STAT_BASE) begin
            rdata_d = ctrl_out[(rd_idx - 4)*32 +: 32];
        end else if (rd_idx < MAP_END) begin
            rdata_d = stat_in[(rd_idx - STAT_BASE)*32 +: 32];
        end else begin
            rresp_d = RESP_SLVERR;
        end
    end

    always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
        if (!s00_axi_aresetn) begin
            aw_held_q <= 1'b0;
            aw_idx_q  <= '0;
            w_held_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bresp_q   <= RESP_OKAY;
            rvalid_q  <= 1'b0;
            rresp_q   <= RESP_OKAY;
            rdata_q   <= '0;
            event_q   <= '0;
            pulse_q   <= '0;
        end else begin
            event_q <= event_d;
            pulse_q <= pulse_d;
            if (commit) begin
                aw_held_q <= 1'b0;
                w_held_q  <= 1'b0;
                bvalid_q  <= 1'b1;
                bresp_q   <= bresp_d;
            end else begin
                if (aw_hs) begin
                    aw_held_q <= 1'b1;
                    aw_idx_q  <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held_q <= 1'b1;
                    w_data_q <= s00_axi_wdata;
                    w_strb_q <= s00_axi_wstrb;
                end
                if (bvalid_q && s00_axi_bready) begin
                    bvalid_q <= 1'b0;
                end
            end
            if (ar_hs) begin
                rvalid_q <= 1'b1;
                rdata_q  <= rdata_d;
                rresp_q  <= rresp_d;
            end else if (rvalid_q && s00_axi_rready) begin
                rvalid_q <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_axi_register_bank.sv
// Randomised self-checking bench for axi_register_bank against a word-level register model.
// Follows AXI_REG_BANK_IRQ_EN in the same way as the design.
module tb_axi_register_bank;

    localparam int NC = 4;
    localparam int NS = 4;
    localparam logic [31:0] CRST = 32'hA5C3_9F17;
    localparam logic [31:0] IDV  = 32'h5A4D_0100;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [7:0]  awaddr = '0;
    logic [2:0]  awprot = '0;
    logic        awvalid = 1'b0;
    logic        awready;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        wvalid = 1'b0;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready = 1'b0;
    logic [7:0]  araddr = '0;
    logic [2:0]  arprot = '0;
    logic        arvalid = 1'b0;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready = 1'b0;
    logic [NC*32-1:0] ctrl_out;
    logic [31:0] ctrl_pulse;
    logic [NS*32-1:0] stat_in = '0;
    logic [31:0] event_in = '0;
    logic        irq;

    axi_register_bank #(
        .C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(8), .NUM_CTRL(NC), .NUM_STAT(NS),
        .CTRL_RESET(CRST), .ID_VALUE(IDV)
    ) dut (
        .s00_axi_aclk(clk), .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
        .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
        .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
        .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
        .ctrl_out(ctrl_out), .ctrl_pulse(ctrl_pulse), .stat_in(stat_in), .event_in(event_in), .irq(irq)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model of the register file
    logic [31:0] ctrl_m [NC];
    logic [31:0] event_m;
    logic [31:0] irq_en_m;

    function automatic logic [31:0] bmask(input logic [3:0] s);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{s[i]}};
        return m;
    endfunction

    function automatic logic [NC*32-1:0] ctrl_vec();
        logic [NC*32-1:0] v;
        for (int i = 0; i < NC; i++) v[i*32 +: 32] = ctrl_m[i];
        return v;
    endfunction

    function automatic logic irq_model();
`ifdef AXI_REG_BANK_IRQ_EN
        return |(event_m & irq_en_m);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NC; i++) ctrl_m[i] = CRST;
        event_m = '0;
        irq_en_m = '0;
    endtask

    task automatic model_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                               output logic [1:0] resp, output logic [31:0] pulse);
        logic [31:0] m;
        m = bmask(s);
        resp = 2'b00;
        pulse = '0;
        if (idx == 0) resp = 2'b10;
        else if (idx == 1) event_m = event_m & ~(d & m);
        else if (idx == 2) begin
`ifdef AXI_REG_BANK_IRQ_EN
            irq_en_m = (irq_en_m & ~m) | (d & m);
`endif
        end
        else if (idx == 3) pulse = d & m;
        else if (idx < 4 + NC) ctrl_m[idx-4] = (ctrl_m[idx-4] & ~m) | (d & m);
        else resp = 2'b10;
    endtask

    task automatic model_read(input int idx, output logic [31:0] d, output logic [1:0] resp);
        d = '0;
        resp = 2'b00;
        if (idx == 0) d = IDV;
        else if (idx == 1) d = event_m;
        else if (idx == 2) d = irq_en_m;
        else if (idx == 3) d = '0;
        else if (idx < 4 + NC) d = ctrl_m[idx-4];
        else if (idx < 4 + NC + NS) d = stat_in[(idx-4-NC)*32 +: 32];
        else resp = 2'b10;
    endtask

    // Bus driver: starts and ends #1 after a rising edge. lat = cycles from commit edge to bvalid.
    task automatic axi_write(input int idx, input logic [31:0] d, input logic [3:0] s,
                             input int aw_dly, input int w_dly,
                             output logic [1:0] resp, output int lat,
                             output logic [31:0] pulse_b, output logic irq_b);
        int  c = 0;
        bit  aw_done = 0, w_done = 0, aw_hs, w_hs;
        awaddr = {6'(idx), 2'($urandom_range(0, 3))};
        wdata = d;
        wstrb = s;
        while (!(aw_done && w_done) && c < 50) begin
            awvalid = !aw_done && (c >= aw_dly);
            wvalid  = !w_done && (c >= w_dly);
            @(negedge clk);
            aw_hs = awvalid && awready;
            w_hs  = wvalid && wready;
            @(posedge clk);
            #1;
            if (aw_hs) aw_done = 1;
            if (w_hs) w_done = 1;
            c++;
        end
        awvalid = 1'b0;
        wvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!bvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        resp = bresp;
        pulse_b = ctrl_pulse;
        irq_b = irq;
        if (!bvalid || !(aw_done && w_done)) lat = -1;
        bready = 1'b1;
        @(posedge clk);
        #1;
        bready = 1'b0;
        $display("[TB] WR word=%0d data=%08h strb=%b resp=%0d lat=%0d", idx, d, s, resp, lat);
    endtask

    task automatic axi_read(input int idx, output logic [31:0] d, output logic [1:0] resp, output int lat);
        int c = 0;
        bit done = 0;
        araddr = {6'(idx), 2'($urandom_range(0, 3))};
        arvalid = 1'b1;
        while (!done && c < 50) begin
            @(negedge clk);
            done = arready;
            @(posedge clk);
            #1;
            c++;
        end
        arvalid = 1'b0;
        lat = 1;
        @(negedge clk);
        while (!rvalid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        d = rdata;
        resp = rresp;
        if (!rvalid || !done) lat = -1;
        rready = 1'b1;
        @(posedge clk);
        #1;
        rready = 1'b0;
        $display("[TB] RD word=%0d data=%08h resp=%0d lat=%0d", idx, d, resp, lat);
    endtask

    task automatic test_reset();
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        tests_run++;
        if ({awready, wready, arready, bvalid, rvalid} !== 5'b11100) begin
            tests_failed++;
            $display("FAIL reset_handshake got=%b exp=11100", {awready, wready, arready, bvalid, rvalid});
        end
        tests_run++;
        if ({bresp, rresp, rdata, ctrl_pulse, irq} !== '0) begin
            tests_failed++;
            $display("FAIL reset_resp got bresp=%0d rresp=%0d rdata=%08h pulse=%08h irq=%b exp all 0",
                     bresp, rresp, rdata, ctrl_pulse, irq);
        end
        tests_run++;
        if (ctrl_out !== ctrl_vec()) begin
            tests_failed++;
            $display("FAIL reset_ctrl got=%032h exp=%032h", ctrl_out, ctrl_vec());
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_id_ctrl_read();
        logic [31:0] d;
        logic [1:0] r;
        int lat;
        axi_read(0, d, r, lat);
        tests_run++;
        if ({d, r, 8'(lat)} !== {IDV, 2'b00, 8'd1}) begin
            tests_failed++;
            $display("FAIL read_id got data=%08h resp=%0d lat=%0d exp data=%08h resp=0 lat=1", d, r, lat, IDV);
        end
        axi_read(4, d, r, lat);
        tests_run++;
        if ({d, r, 8'(lat)} !== {CRST, 2'b00, 8'd1}) begin
            tests_failed++;
            $display("FAIL read_ctrl0 got data=%08h resp=%0d lat=%0d exp data=%08h resp=0 lat=1", d, r, lat, CRST);
        end
    endtask

    task automatic test_aw_before_w();
        logic [1:0] r, er;
        logic [31:0] p, ep;
        logic ib;
        int lat;
        model_write(4, 32'hDEAD_BEEF, 4'b0101, er, ep);
        axi_write(4, 32'hDEAD_BEEF, 4'b0101, 0, 3, r, lat, p, ib);
        tests_run++;
        if (r !== 2'b00 || lat != 1) begin
            tests_failed++;
            $display("FAIL aw_first_resp got resp=%0d lat=%0d exp resp=0 lat=1", r, lat);
        end
        tests_run++;
        if (ctrl_out[31:0] !== 32'hA5AD_9FEF) begin
            tests_failed++;
            $display("FAIL aw_first_strobe got=%08h exp=a5ad9fef", ctrl_out[31:0]);
        end
    endtask

    task automatic test_event_irq();
        logic [1:0] r, er;
        logic [31:0] p, ep, d;
        logic ib, exp_irq_b;
        int lat;
        event_in = 32'h8;
        @(posedge clk);
        #1;
        event_in = '0;
        event_m = event_m | 32'h8;
        model_write(2, 32'h8, 4'hF, er, ep);
        axi_write(2, 32'h8, 4'hF, 0, 0, r, lat, p, ib);
        @(negedge clk);
        tests_run++;
        if (irq !== irq_model() || r !== er) begin
            tests_failed++;
            $display("FAIL irq_enable got irq=%b resp=%0d exp irq=%b resp=%0d", irq, r, irq_model(), er);
        end
        @(posedge clk);
        #1;
        event_in = 32'h8;
        model_write(1, 32'h8, 4'hF, er, ep);
        event_m = event_m | 32'h8;
        axi_write(1, 32'h8, 4'hF, 0, 0, r, lat, p, ib);
        event_in = '0;
        axi_read(1, d, r, lat);
        tests_run++;
        if (d !== event_m || d[3] !== 1'b1) begin
            tests_failed++;
            $display("FAIL event_set_wins got=%08h exp=%08h", d, event_m);
        end
        exp_irq_b = irq_model();
        model_write(1, 32'h8, 4'hF, er, ep);
        axi_write(1, 32'h8, 4'hF, 0, 0, r, lat, p, ib);
        tests_run++;
        if (ib !== exp_irq_b) begin
            tests_failed++;
            $display("FAIL irq_lag got=%b exp=%b", ib, exp_irq_b);
        end
        @(negedge clk);
        tests_run++;
        if (irq !== irq_model() || irq !== 1'b0) begin
            tests_failed++;
            $display("FAIL irq_clear got=%b exp=0", irq);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_pulse();
        logic [1:0] r, er;
        logic [31:0] p, ep, d;
        logic ib;
        int lat;
        model_write(3, 32'h11, 4'hF, er, ep);
        axi_write(3, 32'h11, 4'hF, 1, 0, r, lat, p, ib);
        tests_run++;
        if (p !== 32'h11 || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL pulse_value got=%08h resp=%0d exp=00000011 resp=0", p, r);
        end
        @(negedge clk);
        tests_run++;
        if (ctrl_pulse !== 32'h0) begin
            tests_failed++;
            $display("FAIL pulse_width got=%08h exp=00000000", ctrl_pulse);
        end
        @(posedge clk);
        #1;
        model_write(3, 32'hFFFF_FFFF, 4'b0010, er, ep);
        axi_write(3, 32'hFFFF_FFFF, 4'b0010, 0, 2, r, lat, p, ib);
        tests_run++;
        if (p !== ep) begin
            tests_failed++;
            $display("FAIL pulse_strobe got=%08h exp=%08h", p, ep);
        end
        axi_read(3, d, r, lat);
        tests_run++;
        if (d !== 32'h0 || r !== 2'b00) begin
            tests_failed++;
            $display("FAIL pulse_read got=%08h resp=%0d exp=0 resp=0", d, r);
        end
    endtask

    task automatic test_slverr();
        logic [1:0] r, er;
        logic [31:0] p, ep, d;
        logic ib;
        int lat;
        model_write(0, 32'h1234_5678, 4'hF, er, ep);
        axi_write(0, 32'h1234_5678, 4'hF, 0, 0, r, lat, p, ib);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL wr_id_slverr got=%0d exp=2", r);
        end
        model_write(4 + NC, 32'h1, 4'hF, er, ep);
        axi_write(4 + NC, 32'h1, 4'hF, 0, 0, r, lat, p, ib);
        tests_run++;
        if (r !== 2'b10) begin
            tests_failed++;
            $display("FAIL wr_stat_slverr got=%0d exp=2", r);
        end
        axi_read(0, d, r, lat);
        tests_run++;
        if (d !== IDV) begin
            tests_failed++;
            $display("FAIL id_unchanged got=%08h exp=%08h", d, IDV);
        end
        axi_read(14, d, r, lat);
        tests_run++;
        if (d !== 32'h0 || r !== 2'b10) begin
            tests_failed++;
            $display("FAIL rd_unmapped got data=%08h resp=%0d exp data=0 resp=2", d, r);
        end
    endtask

    task automatic test_backpressure();
        logic [1:0] er;
        logic [31:0] ep, exp_rd, wd;
        logic [40:0] got, exp;
        for (int i = 0; i < NS; i++) stat_in[i*32 +: 32] = $urandom;
        exp_rd = ctrl_m[2];
        wd = $urandom;
        awaddr = 8'(5 * 4);
        wdata = wd;
        wstrb = 4'hF;
        araddr = 8'(6 * 4);
        awvalid = 1'b1;
        wvalid = 1'b1;
        arvalid = 1'b1;
        @(negedge clk);
        tests_run++;
        if ({awready, wready, arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL bp_accept got=%b exp=111", {awready, wready, arready});
        end
        @(posedge clk);
        #1;
        awvalid = 1'b0;
        wvalid = 1'b0;
        arvalid = 1'b0;
        model_write(5, wd, 4'hF, er, ep);
        exp = {1'b1, 2'b00, 1'b1, 2'b00, exp_rd, 3'b000};
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            got = {bvalid, bresp, rvalid, rresp, rdata, awready, wready, arready};
            tests_run++;
            if (got !== exp) begin
                tests_failed++;
                $display("FAIL bp_hold cycle=%0d got=%011h exp=%011h", c, got, exp);
            end
        end
        tests_run++;
        if (ctrl_out !== ctrl_vec()) begin
            tests_failed++;
            $display("FAIL bp_commit got=%032h exp=%032h", ctrl_out, ctrl_vec());
        end
        #2;
        rst_n = 1'b0;
        #1;
        tests_run++;
        if ({bvalid, rvalid} !== 2'b00) begin
            tests_failed++;
            $display("FAIL async_reset got bvalid=%b rvalid=%b exp 0 0", bvalid, rvalid);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        tests_run++;
        if (ctrl_out !== ctrl_vec() || {awready, wready, arready} !== 3'b111) begin
            tests_failed++;
            $display("FAIL reset_restore got ctrl=%032h rdy=%b exp ctrl=%032h rdy=111",
                     ctrl_out, {awready, wready, arready}, ctrl_vec());
        end
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_random();
        logic [1:0] r, er;
        logic [31:0] p, ep, d, ed, wd;
        logic [3:0] s;
        logic ib;
        int lat, idx;
        for (int n = 0; n < 40; n++) begin
            idx = $urandom_range(0, 15);
            if ($urandom_range(0, 1) == 1) begin
                wd = $urandom;
                s = 4'($urandom_range(0, 15));
                model_write(idx, wd, s, er, ep);
                axi_write(idx, wd, s, $urandom_range(0, 3), $urandom_range(0, 3), r, lat, p, ib);
                tests_run++;
                if (r !== er || lat != 1 || p !== ep || ctrl_out !== ctrl_vec()) begin
                    tests_failed++;
                    $display("FAIL rand_wr n=%0d word=%0d got resp=%0d lat=%0d pulse=%08h ctrl=%032h exp resp=%0d lat=1 pulse=%08h ctrl=%032h",
                             n, idx, r, lat, p, ctrl_out, er, ep, ctrl_vec());
                end
                @(negedge clk);
                tests_run++;
                if (irq !== irq_model()) begin
                    tests_failed++;
                    $display("FAIL rand_irq n=%0d got=%b exp=%b", n, irq, irq_model());
                end
                @(posedge clk);
                #1;
            end else begin
                for (int i = 0; i < NS; i++) stat_in[i*32 +: 32] = $urandom;
                model_read(idx, ed, er);
                axi_read(idx, d, r, lat);
                tests_run++;
                if (d !== ed || r !== er || lat != 1) begin
                    tests_failed++;
                    $display("FAIL rand_rd n=%0d word=%0d got data=%08h resp=%0d lat=%0d exp data=%08h resp=%0d lat=1",
                             n, idx, d, r, lat, ed, er);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_id_ctrl_read();
        test_aw_before_w();
        test_event_irq();
        test_pulse();
        test_slverr();
        test_backpressure();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
